// File: rtl/y_row_unpack_pkg.sv
// rtl/y_row_unpack_pkg.sv - shared types, widths and row/index helper for Y-matrix blocks
package y_row_unpack_pkg;

    localparam int DEF_ELEM_W = 16;
    localparam int DEF_ELEMS  = 16;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_OFF_W  = 4;
    localparam int INDEX_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Matrix row index of element `offset` in SRAM row `addr` (16 rows per word).
    function automatic logic [INDEX_W-1:0] row_to_index(
        input logic [DEF_ADDR_W-1:0] addr,
        input logic [DEF_OFF_W-1:0]  offset
    );
        return INDEX_W'({addr, offset});
    endfunction

endpackage

// File: rtl/y_row_unpack_if.sv
// rtl/y_row_unpack_if.sv - request, SRAM read and element stream signals of the row unpacker
interface y_row_unpack_if #(
    parameter int ELEM_W = y_row_unpack_pkg::DEF_ELEM_W,
    parameter int ELEMS  = y_row_unpack_pkg::DEF_ELEMS,
    parameter int ADDR_W = y_row_unpack_pkg::DEF_ADDR_W
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_addr;
    logic                    sram_rd_en;
    logic [ADDR_W-1:0]       sram_addr;
    logic [ELEMS*ELEM_W-1:0] sram_rdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [ELEM_W-1:0]       out_data;
    logic [15:0]             out_index;
    logic                    out_last;

    modport slave (
        input  req_valid, req_addr, sram_rdata, out_ready,
        output req_ready, sram_rd_en, sram_addr, out_valid, out_data, out_index, out_last
    );

    modport master (
        output req_valid, req_addr, sram_rdata, out_ready,
        input  req_ready, sram_rd_en, sram_addr, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/y_row_unpack.sv
// rtl/y_row_unpack.sv - reads one packed SRAM row and streams its elements with matrix row indices
module y_row_unpack
    import y_row_unpack_pkg::*;
#(
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int ELEMS    = DEF_ELEMS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SRAM_LAT = 1
) (
    input logic           clock,
    input logic           reset,
    y_row_unpack_if.slave bus
);

    localparam int OFF_W = $clog2(ELEMS);
    localparam int LAT_W = 3;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(ELEMS - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(SRAM_LAT);

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_W-1:0]       addrReg;
    logic [ELEMS*ELEM_W-1:0] wordReg;
    logic [OFF_W-1:0]        offset;
    logic [LAT_W-1:0]        latCnt;
    logic                    rdEn;

    logic reqFire;
    logic outFire;
    logic lastBeat;
    logic captureNow;

    always_comb begin
        reqFire    = (state == IDLE) && bus.req_valid;
        outFire    = (state == STREAM) && bus.out_ready;
        lastBeat   = (state == STREAM) && (offset == LAST_OFF);
        // latCnt==0 is the strobe cycle, so data lands SRAM_LAT cycles later
        captureNow = (state == WAIT) && (latCnt == LAT_END);
        stateNext  = state;
        case (state)
            IDLE:    if (reqFire) stateNext = WAIT;
            WAIT:    if (captureNow) stateNext = STREAM;
            STREAM:  if (outFire && lastBeat) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addrReg <= '0;
            wordReg <= '0;
            offset  <= '0;
            latCnt  <= '0;
            rdEn    <= 1'b0;
        end else begin
            rdEn <= reqFire;
            if (reqFire) begin
                addrReg <= bus.req_addr;
                latCnt  <= '0;
            end
            if ((state == WAIT) && !captureNow) begin
                latCnt <= latCnt + 1'b1;
            end
            if (captureNow) begin
                wordReg <= bus.sram_rdata;
                offset  <= '0;
            end
            if (outFire) begin
                offset <= offset + 1'b1;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.sram_rd_en = rdEn;
    assign bus.sram_addr  = addrReg;
    assign bus.out_valid  = (state == STREAM);
    assign bus.out_data   = (state == STREAM) ? wordReg[offset*ELEM_W +: ELEM_W] : '0;
    assign bus.out_index  = (state == STREAM) ? INDEX_W'({addrReg, offset}) : '0;
    assign bus.out_last   = lastBeat;

endmodule

// File: tb/tb_y_row_unpack.sv
// tb/tb_y_row_unpack.sv - randomized self-checking bench for y_row_unpack against a queue model
module tb_y_row_unpack;
    import y_row_unpack_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    y_row_unpack_if busA ();
    y_row_unpack_if busB ();

    y_row_unpack #(.SRAM_LAT(LAT_A)) dutA (.clock(clock), .reset(reset), .bus(busA));
    y_row_unpack #(.SRAM_LAT(LAT_B)) dutB (.clock(clock), .reset(reset), .bus(busB));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [255:0] mem [2048];

    function automatic logic [15:0] elemOf(input int a, input int k);
        return mem[a][k*16 +: 16];
    endfunction

    // SRAM models: data valid exactly LAT cycles after the strobe cycle, noise otherwise
    logic [LAT_A-1:0] pvA = '0;
    logic [10:0]      paA [LAT_A];
    logic [255:0]     noiseA = '0;
    always @(posedge clock) begin
        pvA    <= LAT_A'({pvA, busA.sram_rd_en});
        paA[0] <= busA.sram_addr;
        for (int i = LAT_A - 1; i > 0; i--) paA[i] <= paA[i-1];
        noiseA <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    assign busA.sram_rdata = pvA[LAT_A-1] ? mem[paA[LAT_A-1]] : noiseA;

    logic [LAT_B-1:0] pvB = '0;
    logic [10:0]      paB [LAT_B];
    logic [255:0]     noiseB = '0;
    always @(posedge clock) begin
        pvB    <= LAT_B'({pvB, busB.sram_rd_en});
        paB[0] <= busB.sram_addr;
        for (int i = LAT_B - 1; i > 0; i--) paB[i] <= paB[i-1];
        noiseB <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    assign busB.sram_rdata = pvB[LAT_B-1] ? mem[paB[LAT_B-1]] : noiseB;

    // Expected beats: one row pushes 16 entries of (element, addr*16+k, k==15)
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] index;
        logic        last;
    } beat_t;
    beat_t expq[$];

    int          rdPulses = 0;
    int          beatsInRow = 0;
    int          lastFlags = 0;
    int          stallCnt = 0;
    int          rowsAccepted = 0;
    logic [15:0] firstIdx = '0;
    logic [15:0] lastIdx = '0;
    logic [15:0] lastData = '0;
    logic [10:0] lastReqAddr = '0;
    bit          prevStall = 0;
    bit          prevLast = 0;

    always @(negedge clock) begin
        beat_t b;
        if (!reset) begin
            expq.delete();
            prevStall = 0;
            prevLast  = 0;
        end else begin
            if (prevLast) begin
                chk("ready_after_last", busA.req_ready, 1);
                chk("valid_after_last", busA.out_valid, 0);
            end
            if (prevStall) chk("no_withdraw", busA.out_valid, 1);
            if (busA.sram_rd_en) begin
                rdPulses++;
                chk("sram_addr", busA.sram_addr, lastReqAddr);
            end
            if (busA.req_valid && busA.req_ready) begin
                chk("req_while_owed", expq.size(), 0);
                lastReqAddr = busA.req_addr;
                rowsAccepted++;
                for (int k = 0; k < 16; k++) begin
                    b.data  = elemOf(int'(busA.req_addr), k);
                    b.index = 16'(int'(busA.req_addr) * 16 + k);
                    b.last  = (k == 15);
                    expq.push_back(b);
                end
            end
            prevLast  = 0;
            prevStall = 0;
            if (busA.out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", busA.out_valid, 0);
                end else begin
                    b = expq[0];
                    chk("out_data", busA.out_data, b.data);
                    chk("out_index", busA.out_index, b.index);
                    chk("out_last", busA.out_last, b.last);
                    if (busA.out_ready) begin
                        void'(expq.pop_front());
                        if (beatsInRow == 0) firstIdx = busA.out_index;
                        beatsInRow++;
                        lastIdx  = busA.out_index;
                        lastData = busA.out_data;
                        if (busA.out_last) lastFlags++;
                        prevLast = busA.out_last;
                    end else begin
                        prevStall = 1;
                        stallCnt++;
                    end
                end
            end
        end
    end

    int readyMode = 0;
    int patCnt = 0;
    always @(posedge clock) begin
        #1;
        case (readyMode)
            0:       busA.out_ready = 1'b1;
            1: begin
                busA.out_ready = (patCnt % 4 == 0) || (patCnt % 4 == 3);
                patCnt++;
            end
            default: busA.out_ready = 1'($urandom);
        endcase
    end

    task automatic clearRow();
        rdPulses = 0;
        beatsInRow = 0;
        lastFlags = 0;
        stallCnt = 0;
    endtask

    task automatic reqA(input logic [10:0] a, output int lat);
        int n;
        @(posedge clock); #1;
        busA.req_valid = 1'b1;
        busA.req_addr  = a;
        n = 0;
        while (!busA.req_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) chk("req_timeout", n, 0);
        @(posedge clock); #1;
        busA.req_valid = 1'b0;
        busA.req_addr  = 11'($urandom);
        lat = 0;
        while (!busA.out_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic waitDoneA();
        int n;
        n = 0;
        while ((expq.size() != 0 || !busA.req_ready) && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("row_done_in_time", n < 1000, 1);
    endtask

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog expired total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lat;
        int n;
        int rowsBefore;
        for (int a = 0; a < 2048; a++)
            for (int w = 0; w < 8; w++) mem[a][w*32 +: 32] = $urandom;
        for (int k = 0; k < 16; k++) mem[5][k*16 +: 16] = 16'hA000 + 16'(k);

        busA.req_valid = 0; busA.req_addr = '0;
        busB.req_valid = 0; busB.req_addr = '0; busB.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", busA.req_ready, 1);
        chk("rst_out_valid", busA.out_valid, 0);
        chk("rst_sram_rd_en", busA.sram_rd_en, 0);
        chk("rst_sram_addr", busA.sram_addr, 0);
        chk("rst_out_data", busA.out_data, 0);
        chk("rst_out_index", busA.out_index, 0);
        chk("rst_out_last", busA.out_last, 0);
        @(negedge clock);
        reset = 1'b1;

        // Row 5 with full throughput
        readyMode = 0;
        clearRow();
        reqA(11'd5, lat);
        chk("lat1_first_valid", lat, LAT_A + 1);
        waitDoneA();
        chk("row5_rd_pulses", rdPulses, 1);
        chk("row5_beats", beatsInRow, 16);
        chk("row5_first_idx", firstIdx, 80);
        chk("row5_last_idx", lastIdx, 95);
        chk("row5_last_data", lastData, 16'hA00F);
        chk("row5_last_flags", lastFlags, 1);

        // Backpressure 1,0,0,1
        readyMode = 1;
        patCnt = 0;
        clearRow();
        reqA(11'd18, lat);
        waitDoneA();
        chk("bp_beats", beatsInRow, 16);
        chk("bp_stalled", stallCnt > 0, 1);
        chk("bp_last_idx", lastIdx, 18 * 16 + 15);

        // Boundary addresses
        readyMode = 0;
        clearRow();
        reqA(11'd0, lat);
        waitDoneA();
        chk("addr0_first_idx", firstIdx, 0);
        chk("addr0_last_idx", lastIdx, 15);
        clearRow();
        reqA(11'd2047, lat);
        waitDoneA();
        chk("addr2047_first_idx", firstIdx, 32752);
        chk("addr2047_last_idx", lastIdx, 32767);
        chk("addr2047_msb", lastIdx[15], 0);

        // Back-to-back with req_valid held
        clearRow();
        @(posedge clock); #1;
        busA.req_valid = 1'b1;
        busA.req_addr  = 11'd7;
        n = 0;
        while (!busA.req_ready && n < 100) begin @(posedge clock); #1; n++; end
        @(posedge clock); #1;
        busA.req_addr = 11'd8;
        n = 0;
        while (!busA.req_ready && n < 100) begin @(posedge clock); #1; n++; end
        chk("b2b_second_accept", n < 100, 1);
        @(posedge clock); #1;
        busA.req_valid = 1'b0;
        waitDoneA();
        chk("b2b_beats", beatsInRow, 32);
        chk("b2b_first_idx", firstIdx, 112);
        chk("b2b_last_idx", lastIdx, 143);
        chk("b2b_rd_pulses", rdPulses, 2);

        // Random requests, addresses wiggling while busy, random out_ready
        readyMode = 2;
        rowsBefore = rowsAccepted;
        for (int c = 0; c < 600; c++) begin
            @(posedge clock); #1;
            busA.req_valid = ($urandom % 3 == 0);
            busA.req_addr  = 11'($urandom);
        end
        busA.req_valid = 1'b0;
        waitDoneA();
        chk("random_rows_seen", (rowsAccepted - rowsBefore) >= 3, 1);

        // Reset while streaming at offset 6
        readyMode = 0;
        clearRow();
        reqA(11'd10, lat);
        n = 0;
        while (beatsInRow < 6 && n < 100) begin @(negedge clock); #1; n++; end
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", busA.out_valid, 0);
        chk("midrst_req_ready", busA.req_ready, 1);
        chk("midrst_out_data", busA.out_data, 0);
        chk("midrst_out_index", busA.out_index, 0);
        chk("midrst_out_last", busA.out_last, 0);
        chk("midrst_rd_en", busA.sram_rd_en, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        clearRow();
        reqA(11'd3, lat);
        waitDoneA();
        chk("postrst_beats", beatsInRow, 16);
        chk("postrst_first_idx", firstIdx, 48);
        chk("postrst_last_idx", lastIdx, 63);

        // SRAM_LAT=3 instance, directly checked
        @(posedge clock); #1;
        busB.req_valid = 1'b1;
        busB.req_addr  = 11'd9;
        @(posedge clock); #1;
        busB.req_valid = 1'b0;
        lat = 0;
        while (!busB.out_valid && lat < 50) begin @(posedge clock); #1; lat++; end
        chk("lat3_first_valid", lat, LAT_B + 1);
        for (int k = 0; k < 16; k++) begin
            chk("lat3_valid", busB.out_valid, 1);
            chk("lat3_data", busB.out_data, elemOf(9, k));
            chk("lat3_index", busB.out_index, 144 + k);
            chk("lat3_last", busB.out_last, k == 15);
            @(posedge clock); #1;
        end
        chk("lat3_idle_valid", busB.out_valid, 0);
        chk("lat3_idle_ready", busB.req_ready, 1);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
